conv_scheduler: RTL and testbench

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_pkg.sv | 17 +
 rtl/kernel_walker.sv | 40 ++++
 rtl/conv_scheduler.sv | 97 +++++++++
 tb/tb_conv_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution scheduler: the FSM state type and
// the helper that derives the output edge length from image/kernel sizes.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Valid-convolution output edge length (no padding, stride 1).
    function automatic int out_size(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/kernel_walker.sv
// Two-level row-major index walk over an N x N grid. The low index advances
// on every enabled cycle and carries into the high index; both wrap to 0
// after the final element, so a finished walk is ready for the next one.
module kernel_walker #(
    parameter int N         = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 clear,
    input  logic                 en,
    output logic [WIDTH_BIT-1:0] hi,
    output logic [WIDTH_BIT-1:0] lo,
    output logic                 last
);

    localparam logic [WIDTH_BIT-1:0] MAX_IDX = WIDTH_BIT'(N - 1);
    localparam logic [WIDTH_BIT-1:0] ONE     = {{(WIDTH_BIT-1){1'b0}}, 1'b1};

    // Index registers: clear wins over enable; carry from lo into hi on wrap.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            hi <= '0;
            lo <= '0;
        end else if (clear) begin
            hi <= '0;
            lo <= '0;
        end else if (en) begin
            if (lo == MAX_IDX) begin
                lo <= '0;
                hi <= (hi == MAX_IDX) ? '0 : hi + ONE;
            end else begin
                lo <= lo + ONE;
            end
        end
    end

    assign last = (hi == MAX_IDX) && (lo == MAX_IDX);

endmodule

// File: rtl/conv_scheduler.sv
// Convolution pass scheduler: walks every output window in row-major order,
// spends K_SIZE*K_SIZE cycles driving the MAC per window, then presents the
// window result and waits for the downstream handshake before moving on.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_SIZE  = 5,
    parameter int K_SIZE    = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 start,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 mac_en,
    output logic                 acc_clr,
    output logic [WIDTH_BIT-1:0] ki,
    output logic [WIDTH_BIT-1:0] kj,
    output logic [WIDTH_BIT-1:0] img_r,
    output logic [WIDTH_BIT-1:0] img_c,
    output logic [WIDTH_BIT-1:0] out_r,
    output logic [WIDTH_BIT-1:0] out_c,
    output logic                 out_valid
);

    localparam int OUT_SIZE = out_size(IMG_SIZE, K_SIZE);

    state_t state;
    state_t state_nxt;
    logic   k_last;
    logic   o_last;
    logic   k_step;
    logic   o_step;
    logic   in_idle;

    assign in_idle = (state == IDLE);
    assign k_step  = (state == MAC);
    assign o_step  = (state == EMIT) && out_ready;

    kernel_walker #(
        .N         (K_SIZE),
        .WIDTH_BIT (WIDTH_BIT)
    ) u_kernel (
        .clock  (clock),
        .nreset (nreset),
        .clear  (in_idle),
        .en     (k_step),
        .hi     (ki),
        .lo     (kj),
        .last   (k_last)
    );

    kernel_walker #(
        .N         (OUT_SIZE),
        .WIDTH_BIT (WIDTH_BIT)
    ) u_outpos (
        .clock  (clock),
        .nreset (nreset),
        .clear  (in_idle),
        .en     (o_step),
        .hi     (out_r),
        .lo     (out_c),
        .last   (o_last)
    );

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start and out_ready only matter in IDLE and EMIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (k_last) state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = o_last ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mac_en    = (state == MAC);
    assign acc_clr   = (state == MAC) && (ki == '0) && (kj == '0);
    assign out_valid = (state == EMIT);
    assign img_r     = out_r + ki;
    assign img_c     = out_c + kj;

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: a 5x5/3x3 instance and a 3x3/3x3 instance,
// checked cycle by cycle against a window/kernel loop model of the pass.
module tb_conv_scheduler;

    logic       clock = 1'b0;
    logic       nreset = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       out_ready = 1'b0;

    logic       busy_a, done_a, mac_en_a, acc_clr_a, out_valid_a;
    logic [7:0] ki_a, kj_a, img_r_a, img_c_a, out_r_a, out_c_a;
    logic       busy_b, done_b, mac_en_b, acc_clr_b, out_valid_b;
    logic [7:0] ki_b, kj_b, img_r_b, img_c_b, out_r_b, out_c_b;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clock = ~clock;

    conv_scheduler #(.IMG_SIZE(5), .K_SIZE(3), .WIDTH_BIT(8)) dut_a (
        .clock(clock), .nreset(nreset), .start(start_a), .out_ready(out_ready),
        .busy(busy_a), .done(done_a), .mac_en(mac_en_a), .acc_clr(acc_clr_a),
        .ki(ki_a), .kj(kj_a), .img_r(img_r_a), .img_c(img_c_a),
        .out_r(out_r_a), .out_c(out_c_a), .out_valid(out_valid_a)
    );

    conv_scheduler #(.IMG_SIZE(3), .K_SIZE(3), .WIDTH_BIT(8)) dut_b (
        .clock(clock), .nreset(nreset), .start(start_b), .out_ready(out_ready),
        .busy(busy_b), .done(done_b), .mac_en(mac_en_b), .acc_clr(acc_clr_b),
        .ki(ki_b), .kj(kj_b), .img_r(img_r_b), .img_c(img_c_b),
        .out_r(out_r_b), .out_c(out_c_b), .out_valid(out_valid_b)
    );

    // Vector layout: busy, done, mac_en, acc_clr, out_valid, ki, kj, img_r, img_c, out_r, out_c
    function automatic logic [52:0] obs_vec(input bit sel);
        if (sel)
            return {busy_b, done_b, mac_en_b, acc_clr_b, out_valid_b,
                    ki_b, kj_b, img_r_b, img_c_b, out_r_b, out_c_b};
        return {busy_a, done_a, mac_en_a, acc_clr_a, out_valid_a,
                ki_a, kj_a, img_r_a, img_c_a, out_r_a, out_c_a};
    endfunction

    function automatic logic [52:0] ev(input bit b, input bit d, input bit m, input bit cl,
                                       input bit v, input int k_i, input int k_j,
                                       input int r, input int c);
        return {b, d, m, cl, v, 8'(k_i), 8'(k_j), 8'(r + k_i), 8'(c + k_j), 8'(r), 8'(c)};
    endfunction

    task automatic chk(input bit sel, input logic [52:0] e, input string tag, input int cyc);
        logic [52:0] o;
        o = obs_vec(sel);
        total++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, o, e);
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic drive_start(input bit sel, input bit v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // One pass. rmode 0: ready tied high; 1: ready low 4 cycles in first EMIT;
    // 2: random ready. abort_at > 0 stops after checking that cycle.
    task automatic run_pass(input bit sel, input int img, input int k,
                            input int rmode, input int abort_at, input string tag);
        int osz, cyc, macs, vals, dcyc, emits;
        logic [52:0] o;
        bit rdy;
        osz = img - k + 1;
        cyc = 0; macs = 0; vals = 0; dcyc = -1; emits = 0;
        @(negedge clock);
        chk(sel, ev(0, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "_idle0"}, cyc);
        drive_start(sel, 1'b1);
        out_ready = (rmode == 0);
        for (int r = 0; r < osz; r++) begin
            for (int c = 0; c < osz; c++) begin
                for (int t = 0; t < k * k; t++) begin
                    @(negedge clock);
                    cyc++;
                    chk(sel, ev(1, 0, 1, t == 0, 0, t / k, t % k, r, c), {tag, "_mac"}, cyc);
                    o = obs_vec(sel);
                    macs += int'(o[50]); vals += int'(o[48]);
                    if (o[51] && dcyc < 0) dcyc = cyc;
                    drive_start(sel, (rmode == 0) ? (cyc == 40) : 1'($urandom_range(0, 1)));
                    out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (cyc == abort_at) return;
                end
                for (int e = 0; e < 16; e++) begin
                    @(negedge clock);
                    cyc++;
                    emits++;
                    chk(sel, ev(1, 0, 0, 0, 1, 0, 0, r, c), {tag, "_emit"}, cyc);
                    o = obs_vec(sel);
                    macs += int'(o[50]); vals += int'(o[48]);
                    if (o[51] && dcyc < 0) dcyc = cyc;
                    case (rmode)
                        0:       rdy = 1'b1;
                        1:       rdy = !(r == 0 && c == 0 && e < 4);
                        default: rdy = (e >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                    endcase
                    out_ready = rdy;
                    drive_start(sel, (rmode == 0) ? (cyc == 40) : 1'($urandom_range(0, 1)));
                    if (cyc == abort_at) return;
                    if (rdy) break;
                end
            end
        end
        @(negedge clock);
        cyc++;
        chk(sel, ev(1, 1, 0, 0, 0, 0, 0, 0, 0), {tag, "_done"}, cyc);
        o = obs_vec(sel);
        if (o[51] && dcyc < 0) dcyc = cyc;
        drive_start(sel, (rmode == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        cyc++;
        chk(sel, ev(0, 0, 0, 0, 0, 0, 0, 0, 0), {tag, "_idle_after"}, cyc);
        drive_start(sel, 1'b0);
        chk_int({tag, "_mac_cycles"}, macs, osz * osz * k * k);
        chk_int({tag, "_valid_cycles"}, vals, emits);
        chk_int({tag, "_done_cycle"}, dcyc, 1 + osz * osz * k * k + emits);
    endtask

    initial begin
        // Reset state, with start asserted during reset.
        #2 nreset = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk(0, '0, "reset_a", 0);
            chk(1, '0, "reset_b", 0);
        end
        nreset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clock);
        chk(0, '0, "idle_after_reset", 0);

        // Baseline pass with a stray start at cycle 40: done at 91.
        run_pass(0, 5, 3, 0, 0, "base");
        // First EMIT stalled 4 cycles: done at 95.
        run_pass(0, 5, 3, 1, 0, "stall");
        // Randomized ready and stray starts.
        for (int i = 0; i < 3; i++) run_pass(0, 5, 3, 2, 0, "rand");

        // Abort at cycle 30, reset, then a fresh pass from window (0,0).
        run_pass(0, 5, 3, 0, 30, "abort");
        nreset = 1'b0;
        #1;
        chk(0, '0, "abort_async_reset", 30);
        start_a = 1'b1;
        @(negedge clock);
        chk(0, '0, "abort_in_reset", 31);
        nreset = 1'b1;
        start_a = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk(0, '0, "abort_no_done", 0);
        end
        run_pass(0, 5, 3, 0, 0, "restart");

        // Single-window configuration: done at cycle 11.
        run_pass(1, 3, 3, 0, 0, "single");
        run_pass(1, 3, 3, 2, 0, "single_rand");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
